// File: rtl/btn_pkg.sv
// Shared constants and channel state type for the push-button conditioner.
// Index names match the operand/opcode load selector bit order.
package btn_pkg;

  localparam int NB_BTN_DEF          = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int DEBOUNCE_CYCLES_HW  = 1_000_000;  // 10 ms at 100 MHz
  localparam int NB_CNT_DEF          = 20;

  localparam int BTN_LOAD_A  = 0;
  localparam int BTN_LOAD_B  = 1;
  localparam int BTN_LOAD_OP = 2;

  typedef enum logic [1:0] {
    CH_RELEASED     = 2'd0,
    CH_PRESS_WAIT   = 2'd1,
    CH_PRESSED      = 2'd2,
    CH_RELEASE_WAIT = 2'd3
  } ch_state_t;

  // Debounced level is high in both pressed-side states.
  function automatic logic ch_level(input ch_state_t st);
    return (st == CH_PRESSED) || (st == CH_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, stability counter and level register.
// The channel state is the (level, counter) pair, decoded onto the state output.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int NB_CNT          = NB_CNT_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      raw,
  output ch_state_t state
);

  localparam logic [NB_CNT-1:0] ACCEPT = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic              sync1;
  logic              sync2;
  logic              level;
  logic              level_n;
  logic [NB_CNT-1:0] cnt;
  logic [NB_CNT-1:0] cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= level_n;
      cnt   <= cnt_n;
    end
  end

  // Any sample matching the current level clears the count, so a bounce restarts it.
  always_comb begin
    level_n = level;
    cnt_n   = '0;
    if (sync2 != level) begin
      if (cnt == ACCEPT) begin
        level_n = sync2;
      end else begin
        cnt_n = cnt + NB_CNT'(1);
      end
    end
  end

  always_comb begin
    state = CH_RELEASED;
    unique case ({level, (cnt != '0)})
      2'b00:   state = CH_RELEASED;
      2'b01:   state = CH_PRESS_WAIT;
      2'b10:   state = CH_PRESSED;
      default: state = CH_RELEASE_WAIT;
    endcase
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces each raw button and emits a registered one-cycle press pulse.
// Simultaneous accepts keep only the lowest index; the others are dropped.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int NB_BTN          = NB_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int NB_CNT          = NB_CNT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NB_BTN-1:0] i_bnt,
  output logic [NB_BTN-1:0] o_bnt,
  output logic [NB_BTN-1:0] o_level
);

  ch_state_t         ch_state [NB_BTN];
  logic [NB_BTN-1:0] level;
  logic [NB_BTN-1:0] level_d;
  logic [NB_BTN-1:0] rise;
  logic [NB_BTN-1:0] pick;

  for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .NB_CNT         (NB_CNT)
    ) u_ch (
      .clk  (i_clk),
      .rst  (i_rst),
      .raw  (i_bnt[gi]),
      .state(ch_state[gi])
    );
    assign level[gi] = ch_level(ch_state[gi]);
  end

  assign rise    = level & ~level_d;
  // Isolate the lowest set bit of rise.
  assign pick    = rise & (~rise + NB_BTN'(1));
  assign o_level = level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level_d <= '0;
      o_bnt   <= '0;
    end else begin
      level_d <= level;
      o_bnt   <= pick;
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: directed scenarios plus random bouncy stimulus,
// all checked against a sample-window reference model of the debounce rules.
module tb_btn_debounce_pulse;

  localparam int NB = 3;
  localparam int DB = 4;
  localparam int NC = 20;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [NB-1:0] i_bnt = '0;
  logic [NB-1:0] o_bnt;
  logic [NB-1:0] o_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  btn_debounce_pulse #(
    .NB_BTN         (NB),
    .DEBOUNCE_CYCLES(DB),
    .NB_CNT         (NC)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_bnt  (i_bnt),
    .o_bnt  (o_bnt),
    .o_level(o_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level change is accepted once the last DB synchronised
  // samples (raw delayed two edges) all disagree with the current level.
  logic [NB-1:0] raw_hist[$];
  logic [NB-1:0] s_hist[$];
  logic [NB-1:0] m_level;
  logic [NB-1:0] m_pend;
  logic [NB-1:0] m_bnt;
  logic [NB-1:0] m_rise;
  logic [NB-1:0] s_now;
  logic          stable;

  function automatic logic [NB-1:0] lowest(input logic [NB-1:0] v);
    logic [NB-1:0] r;
    r = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (v[i]) r = NB'(1 << i);
    end
    return r;
  endfunction

  always @(posedge i_clk) begin
    if (i_rst) begin
      raw_hist.delete();
      raw_hist.push_back('0);
      raw_hist.push_back('0);
      s_hist.delete();
      m_level = '0;
      m_pend  = '0;
      m_bnt   = '0;
    end else begin
      s_now = raw_hist[raw_hist.size() - 2];
      s_hist.push_back(s_now);
      raw_hist.push_back(i_bnt);
      m_bnt  = lowest(m_pend);
      m_rise = '0;
      for (int i = 0; i < NB; i++) begin
        if (s_hist.size() >= DB) begin
          stable = 1'b1;
          for (int j = 0; j < DB; j++) begin
            if (s_hist[s_hist.size() - 1 - j][i] == m_level[i]) stable = 1'b0;
          end
          if (stable) begin
            if (!m_level[i]) m_rise[i] = 1'b1;
            m_level[i] = ~m_level[i];
          end
        end
      end
      m_pend = m_rise;
      while (raw_hist.size() > 32) void'(raw_hist.pop_front());
      while (s_hist.size() > 32) void'(s_hist.pop_front());
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    check("level", 32'(o_level), 32'(m_level));
    check("bnt", 32'(o_bnt), 32'(m_bnt));
    check("onehot", 32'($countones(o_bnt) <= 1), 32'd1);
    check("bnt_known", 32'($isunknown(o_bnt)), 32'd0);
  endtask

  // Runs n edges; reports first tick with o_bnt[b], pulse count on b,
  // first tick with o_level[b], and the OR of every o_bnt seen.
  task automatic watch(input int n, input int b, output int first, output int pulses,
                       output int first_lvl, output logic [NB-1:0] seen);
    first = -1; pulses = 0; first_lvl = -1; seen = '0;
    for (int t = 1; t <= n; t++) begin
      tick();
      seen = seen | o_bnt;
      if (o_bnt[b]) begin
        pulses++;
        if (first < 0) first = t;
      end
      if (o_level[b] && first_lvl < 0) first_lvl = t;
    end
  endtask

  int            f, p, fl;
  logic [NB-1:0] seen;
  logic [NB-1:0] tgt;

  initial begin
    // Reset with all buttons pressed
    i_rst = 1'b1;
    i_bnt = 3'b111;
    repeat (5) begin
      tick();
      check("rst_bnt", 32'(o_bnt), 32'd0);
      check("rst_level", 32'(o_level), 32'd0);
    end
    i_bnt = '0;
    i_rst = 1'b0;
    repeat (4) begin
      tick();
      check("idle_bnt", 32'(o_bnt), 32'd0);
      check("idle_level", 32'(o_level), 32'd0);
    end

    // Clean press, held
    i_bnt = 3'b001;
    watch(20, 0, f, p, fl, seen);
    check("s2_level_lat", 32'(fl), 32'd6);
    check("s2_bnt_lat", 32'(f), 32'd7);
    check("s2_pulses", 32'(p), 32'd1);
    check("s2_seen", 32'(seen), 32'b001);
    i_bnt = '0;
    watch(10, 0, f, p, fl, seen);
    check("s2_release_seen", 32'(seen), 32'd0);
    check("s2_release_level", 32'(o_level), 32'd0);

    // Bounce on bit1
    for (int k = 0; k < 4; k++) begin
      i_bnt = (k % 2 == 0) ? 3'b010 : 3'b000;
      tick();
      check("s3_bounce_bnt", 32'(o_bnt), 32'd0);
    end
    i_bnt = 3'b010;
    watch(14, 1, f, p, fl, seen);
    check("s3_bnt_lat", 32'(f), 32'd7);
    check("s3_pulses", 32'(p), 32'd1);
    check("s3_seen", 32'(seen), 32'b010);
    i_bnt = '0;
    watch(10, 1, f, p, fl, seen);

    // Simultaneous press of bits 1 and 2
    i_bnt = 3'b110;
    watch(12, 1, f, p, fl, seen);
    check("s4_bnt_lat", 32'(f), 32'd7);
    check("s4_pulses", 32'(p), 32'd1);
    check("s4_seen", 32'(seen), 32'b010);
    check("s4_level", 32'(o_level), 32'b110);
    i_bnt = '0;
    watch(10, 1, f, p, fl, seen);

    // Release and re-press
    i_bnt = 3'b001;
    watch(12, 0, f, p, fl, seen);
    check("s5_first_pulses", 32'(p), 32'd1);
    i_bnt = '0;
    watch(8, 0, f, p, fl, seen);
    check("s5_release_level", 32'(o_level), 32'd0);
    i_bnt = 3'b001;
    watch(12, 0, f, p, fl, seen);
    check("s5_repress_lat", 32'(f), 32'd7);
    check("s5_repress_pulses", 32'(p), 32'd1);
    i_bnt = '0;
    repeat (3) begin
      tick();
      check("s5_short_level", 32'(o_level), 32'b001);
    end
    i_bnt = 3'b001;
    watch(12, 0, f, p, fl, seen);
    check("s5_short_seen", 32'(seen), 32'd0);
    check("s5_short_level_end", 32'(o_level), 32'b001);
    i_bnt = '0;
    watch(10, 0, f, p, fl, seen);

    // Reset in the middle of a debounce
    i_bnt = 3'b100;
    tick();
    tick();
    i_rst = 1'b1;
    repeat (2) begin
      tick();
      check("s6_rst_bnt", 32'(o_bnt), 32'd0);
      check("s6_rst_level", 32'(o_level), 32'd0);
    end
    i_rst = 1'b0;
    watch(12, 2, f, p, fl, seen);
    check("s6_bnt_lat", 32'(f), 32'd7);
    check("s6_pulses", 32'(p), 32'd1);
    check("s6_seen", 32'(seen), 32'b100);

    // Random bouncy segments with occasional resets
    for (int seg = 0; seg < 120; seg++) begin
      tgt = NB'($urandom_range(0, 7));
      for (int t = 0; t < int'($urandom_range(1, 12)); t++) begin
        if ($urandom_range(0, 3) == 0) i_bnt = tgt ^ NB'(1 << $urandom_range(0, NB - 1));
        else i_bnt = tgt;
        if ($urandom_range(0, 80) == 0) i_rst = 1'b1;
        else i_rst = 1'b0;
        tick();
      end
    end
    i_rst = 1'b0;
    i_bnt = '0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
